// File: rtl/modred_pipe.sv
// Reduces a 2*LOGQ-bit value (or an a*b product) modulo Q = 2^(LOGQ-1)+1, with the tag carried alongside.
// Latency: 3 cycles from input transfer to out_valid; one beat per cycle while out_ready is high.
// Backpressure: a single global enable stalls every stage whenever a valid output is not being taken.
module modred_pipe #(
  parameter int LOGQ = 17,
  parameter int TAGW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [2*LOGQ-1:0] in_a,
  input  logic [LOGQ-1:0]   in_b,
  input  logic [TAGW-1:0]   in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LOGQ-1:0]   out_data,
  output logic [TAGW-1:0]   out_tag
);

  localparam int K  = LOGQ - 1;
  localparam int XW = 2 * LOGQ;
  localparam int TW = K + 2;
  localparam logic [TW-1:0] QV = {2'b01, {K{1'b0}}} + TW'(1);

  logic            en;
  logic [XW-1:0]   prod;
  logic [TW-1:0]   t_nxt;
  logic [LOGQ-1:0] red;

  logic            s1_vld;
  logic [XW-1:0]   s1_x;
  logic [TAGW-1:0] s1_tag;
  logic            s2_vld;
  logic [TW-1:0]   s2_t;
  logic [TAGW-1:0] s2_tag;

  assign en       = !out_valid || out_ready;
  assign in_ready = rst_n & en;

  assign prod = {{(XW-LOGQ){1'b0}}, in_a[LOGQ-1:0]} * {{(XW-LOGQ){1'b0}}, in_b};

  // 2^K == -1 (mod Q), so x = x0 + x1*2^K + x2*2^2K folds to x0 - x1 + x2.
  assign t_nxt = {2'b00, s1_x[K-1:0]}
               - {2'b00, s1_x[2*K-1:K]}
               + {{K{1'b0}}, s1_x[2*K+1:2*K]};

  always_comb begin
    red = s2_t[LOGQ-1:0];
    if (s2_t[TW-1])
      red = LOGQ'(s2_t + QV);
    else if (s2_t >= QV)
      red = LOGQ'(s2_t - QV);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_x   <= '0;
      s1_tag <= '0;
    end else if (en) begin
      s1_vld <= in_valid;
      s1_x   <= in_mode ? prod : in_a;
      s1_tag <= in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld <= 1'b0;
      s2_t   <= '0;
      s2_tag <= '0;
    end else if (en) begin
      s2_vld <= s1_vld;
      s2_t   <= t_nxt;
      s2_tag <= s1_tag;
    end
  end

  // Output data only moves with a real beat so it reads as the last result between beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (en) begin
      out_valid <= s2_vld;
      if (s2_vld) begin
        out_data <= red;
        out_tag  <= s2_tag;
      end
    end
  end

endmodule

// File: tb/tb_modred_pipe.sv
// Bench for modred_pipe: LOGQ=9 and LOGQ=17 instances share stimulus; a % based reference model
// predicts every accepted beat and the delivered stream is compared in order with tags.
module tb_modred_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_mode;
  logic [33:0] in_a;
  logic [16:0] in_b;
  logic [3:0]  in_tag;
  logic        out_ready;

  logic        in_ready9, out_valid9;
  logic [8:0]  out_data9;
  logic [3:0]  out_tag9;
  logic        in_ready17, out_valid17;
  logic [16:0] out_data17;
  logic [3:0]  out_tag17;

  int errors = 0;
  int checks = 0;
  logic [20:0] exp9[$], got9[$], exp17[$], got17[$];
  logic [3:0]  tagcnt = 4'd0;

  modred_pipe #(.LOGQ(9), .TAGW(4)) dut9 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready9),
    .in_mode(in_mode), .in_a(in_a[17:0]), .in_b(in_b[8:0]), .in_tag(in_tag),
    .out_valid(out_valid9), .out_ready(out_ready), .out_data(out_data9), .out_tag(out_tag9));

  modred_pipe #(.LOGQ(17), .TAGW(4)) dut17 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready17),
    .in_mode(in_mode), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid17), .out_ready(out_ready), .out_data(out_data17), .out_tag(out_tag17));

  always #5 clk = ~clk;

  function automatic logic [16:0] ref9(logic m, logic [33:0] a, logic [16:0] b);
    longint unsigned x;
    x = m ? longint'(a[8:0]) * longint'(b[8:0]) : longint'(a[17:0]);
    return 17'(x % 257);
  endfunction

  function automatic logic [16:0] ref17(logic m, logic [33:0] a, logic [16:0] b);
    longint unsigned x;
    x = m ? longint'(a[16:0]) * longint'(b) : longint'(a);
    return 17'(x % 65537);
  endfunction

  // Records accepted inputs (as predictions) and delivered outputs; comparisons happen in the tests.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready9)  exp9.push_back({in_tag, ref9(in_mode, in_a, in_b)});
      if (in_valid && in_ready17) exp17.push_back({in_tag, ref17(in_mode, in_a, in_b)});
      if (out_valid9 && out_ready)  got9.push_back({out_tag9, 17'(out_data9)});
      if (out_valid17 && out_ready) got17.push_back({out_tag17, out_data17});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) step();
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_valid9 !== 1'b0 || out_valid17 !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid: got %b/%b want 0/0", out_valid9, out_valid17); end
    checks++; if (in_ready9 !== 1'b0 || in_ready17 !== 1'b0) begin errors++;
      $display("FAIL reset_in_ready: got %b/%b want 0/0", in_ready9, in_ready17); end
    checks++; if (out_data9 !== 9'd0 || out_data17 !== 17'd0) begin errors++;
      $display("FAIL reset_out_data: got %0d/%0d want 0/0", out_data9, out_data17); end
    checks++; if (out_tag9 !== 4'd0 || out_tag17 !== 4'd0) begin errors++;
      $display("FAIL reset_out_tag: got %0d/%0d want 0/0", out_tag9, out_tag17); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready9 !== 1'b1 || in_ready17 !== 1'b1) begin errors++;
      $display("FAIL release_in_ready: got %b/%b want 1/1", in_ready9, in_ready17); end
    step();
  endtask

  task automatic test_directed();
    logic        md[8];
    logic [33:0] av[8];
    logic [16:0] bv[8];
    logic [8:0]  want9[6];
    md = '{0, 0, 0, 0, 1, 1, 1, 1};
    av = '{34'd262143, 34'd257, 34'd256, 34'd0, 34'd256, 34'd511, 34'd65536, 34'd0};
    bv = '{17'd0, 17'd0, 17'd0, 17'd0, 17'd256, 17'd511, 17'd65536, 17'd131071};
    want9 = '{9'd3, 9'd0, 9'd256, 9'd0, 9'd1, 9'd9};
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = (i < 8);
      if (i < 8) begin
        in_mode = md[i]; in_a = av[i]; in_b = bv[i]; in_tag = 4'(i);
      end
      @(negedge clk);
      if (i == 2) begin
        checks++; if (out_valid9 !== 1'b0) begin errors++;
          $display("FAIL latency_early: out_valid=%b want 0 in cycle 2", out_valid9); end
      end
      if (i >= 3 && i <= 8) begin
        checks++;
        if (out_valid9 !== 1'b1 || out_data9 !== want9[i-3] || out_tag9 !== 4'(i-3)) begin errors++;
          $display("FAIL directed9 cycle %0d: valid=%b data=%0d tag=%0d want 1/%0d/%0d",
                   i, out_valid9, out_data9, out_tag9, want9[i-3], i-3); end
      end
      if (i == 9) begin
        checks++; if (out_valid17 !== 1'b1 || out_data17 !== 17'd1) begin errors++;
          $display("FAIL directed17_sq: data=%0d want 1", out_data17); end
      end
      if (i == 10) begin
        checks++; if (out_valid17 !== 1'b1 || out_data17 !== 17'd0) begin errors++;
          $display("FAIL directed17_zero: data=%0d want 0", out_data17); end
      end
      @(posedge clk); #1;
    end
    drain();
    checks++; if (got9.size() != exp9.size() || got17.size() != exp17.size()) begin errors++;
      $display("FAIL directed_count: got %0d/%0d want %0d/%0d", got9.size(), got17.size(), exp9.size(), exp17.size()); end
    for (int i = 0; i < exp9.size() && i < got9.size(); i++) begin
      checks++; if (got9[i] !== exp9[i]) begin errors++;
        $display("FAIL directed_q9[%0d]: got %h want %h", i, got9[i], exp9[i]); end
    end
    for (int i = 0; i < exp17.size() && i < got17.size(); i++) begin
      checks++; if (got17[i] !== exp17[i]) begin errors++;
        $display("FAIL directed_q17[%0d]: got %h want %h", i, got17[i], exp17[i]); end
    end
    exp9.delete(); got9.delete(); exp17.delete(); got17.delete();
  endtask

  task automatic test_stall();
    logic [8:0]  hd9;
    logic [16:0] hd17;
    logic [3:0]  ht;
    for (int i = 0; i < 20; i++) begin
      in_valid  = 1'b1;
      in_mode   = 1'($urandom);
      in_a      = 34'({$urandom(), $urandom()});
      in_b      = 17'($urandom);
      in_tag    = tagcnt; tagcnt++;
      out_ready = !(i >= 6 && i < 11);
      @(negedge clk);
      if (i == 6) begin
        hd9 = out_data9; hd17 = out_data17; ht = out_tag9;
      end
      if (i >= 6 && i < 11) begin
        checks++; if (in_ready9 !== 1'b0 || in_ready17 !== 1'b0) begin errors++;
          $display("FAIL stall_in_ready cycle %0d: got %b/%b want 0/0", i, in_ready9, in_ready17); end
        checks++;
        if (out_valid9 !== 1'b1 || out_data9 !== hd9 || out_data17 !== hd17 || out_tag9 !== ht) begin errors++;
          $display("FAIL stall_hold cycle %0d: data=%0d/%0d tag=%0d want %0d/%0d/%0d",
                   i, out_data9, out_data17, out_tag9, hd9, hd17, ht); end
      end
      @(posedge clk); #1;
    end
    drain();
    checks++; if (got9.size() != exp9.size() || got17.size() != exp17.size()) begin errors++;
      $display("FAIL stall_count: got %0d/%0d want %0d/%0d", got9.size(), got17.size(), exp9.size(), exp17.size()); end
    for (int i = 0; i < exp9.size() && i < got9.size(); i++) begin
      checks++; if (got9[i] !== exp9[i]) begin errors++;
        $display("FAIL stall_q9[%0d]: got %h want %h", i, got9[i], exp9[i]); end
    end
    for (int i = 0; i < exp17.size() && i < got17.size(); i++) begin
      checks++; if (got17[i] !== exp17[i]) begin errors++;
        $display("FAIL stall_q17[%0d]: got %h want %h", i, got17[i], exp17[i]); end
    end
    exp9.delete(); got9.delete(); exp17.delete(); got17.delete();
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_mode = 1'b0;
      in_a = 34'(1000 + i); in_b = 17'd0; in_tag = 4'(10 + i);
      step();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid9 !== 1'b0 || out_valid17 !== 1'b0) begin errors++;
      $display("FAIL midreset_valid: got %b/%b want 0/0", out_valid9, out_valid17); end
    checks++; if (out_data9 !== 9'd0 || out_data17 !== 17'd0 || out_tag9 !== 4'd0 || out_tag17 !== 4'd0) begin errors++;
      $display("FAIL midreset_outputs: data=%0d/%0d tag=%0d/%0d want zeros", out_data9, out_data17, out_tag9, out_tag17); end
    exp9.delete(); exp17.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    repeat (10) step();
    checks++; if (got9.size() != 0 || got17.size() != 0) begin errors++;
      $display("FAIL midreset_ghost: got %0d/%0d beats after reset want 0/0", got9.size(), got17.size()); end
    got9.delete(); got17.delete();
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_mode   = 1'($urandom);
      in_a      = 34'({$urandom(), $urandom()});
      in_b      = 17'($urandom);
      if ($urandom_range(0, 15) == 0) in_a = '1;
      if ($urandom_range(0, 15) == 0) in_b = '1;
      in_tag    = tagcnt; tagcnt++;
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();
    checks++; if (got9.size() != exp9.size() || got17.size() != exp17.size()) begin errors++;
      $display("FAIL random_count: got %0d/%0d want %0d/%0d", got9.size(), got17.size(), exp9.size(), exp17.size()); end
    for (int i = 0; i < exp9.size() && i < got9.size(); i++) begin
      checks++; if (got9[i] !== exp9[i]) begin errors++;
        $display("FAIL random_q9[%0d]: got %h want %h", i, got9[i], exp9[i]); end
    end
    for (int i = 0; i < exp17.size() && i < got17.size(); i++) begin
      checks++; if (got17[i] !== exp17[i]) begin errors++;
        $display("FAIL random_q17[%0d]: got %h want %h", i, got17[i], exp17[i]); end
    end
    exp9.delete(); got9.delete(); exp17.delete(); got17.delete();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0;
    in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    test_reset();
    test_directed();
    test_stall();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
